// File: rtl/ysyx_22050019_axi_rd_slave_if.sv
//============================================================================
// Module      : ysyx_22050019_axi_rd_slave_if
// Description : AR/R channel bundle between the fetch master and the read
//               responder.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface ysyx_22050019_axi_rd_slave_if;
    logic [63:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_araddr,
        output s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata,
        input  s_axi_rresp,
        input  s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_araddr,
        input  s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata,
        output s_axi_rresp,
        output s_axi_rvalid,
        input  s_axi_rready
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050019_axi_rd_slave.sv
//============================================================================
// Module      : ysyx_22050019_axi_rd_slave
// Description : Single-outstanding AXI-style read responder for instruction
//               fetch. Adds LAT wait cycles, classifies the address
//               (OKAY / SLVERR / DECERR) and reads one 64-bit word from a
//               synchronous-read memory port.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ysyx_22050019_axi_rd_slave #(
    parameter int          LAT  = 0,
    parameter logic [63:0] BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] SIZE = 64'h0000_0000_0800_0000
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,      // active-high, synchronous
    ysyx_22050019_axi_rd_slave_if.slave      s_axi,
    output logic                             mem_ren,
    output logic [63:0]                      mem_raddr,
    input  wire logic [63:0]                 mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  c_RESP_DECERR = 2'b11;
    localparam logic [63:0] c_LIMIT       = BASE + SIZE;
    // The counter counts LAT-1 down to 0, so LAT wait cycles are spent in WAIT.
    localparam logic [7:0]  c_CNT_LOAD    = (LAT > 0) ? 8'(LAT - 1) : 8'd0;

    state_t      r_state;
    state_t      w_next;
    logic [60:0] r_addr;     // dword-aligned part of the latched address
    logic [1:0]  r_cls;
    logic [7:0]  r_cnt;
    logic [63:0] r_rdata;
    logic [1:0]  r_rresp;

    logic        w_arready;
    logic        w_ar_hs;
    logic        w_in_win;
    logic [1:0]  w_cls;

    // Address is only taken in IDLE, and never while reset is held.
    assign w_arready = (r_state == S_IDLE) && !rst_n;
    assign w_ar_hs   = w_arready && s_axi.s_axi_arvalid;

    // Window decode takes priority over the alignment check.
    assign w_in_win = (s_axi.s_axi_araddr >= BASE) && (s_axi.s_axi_araddr < c_LIMIT);
    assign w_cls    = !w_in_win                        ? c_RESP_DECERR :
                      (s_axi.s_axi_araddr[1:0] != 2'b00) ? c_RESP_SLVERR :
                                                         c_RESP_OKAY;

    assign s_axi.s_axi_arready = w_arready;
    assign s_axi.s_axi_rvalid  = (r_state == S_RESP);
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;

    assign mem_ren   = (r_state == S_ISSUE) && (r_cls == c_RESP_OKAY);
    assign mem_raddr = {r_addr, 3'b000};

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_next = (LAT > 0) ? S_WAIT : S_ISSUE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_CAPT;
            S_CAPT:  w_next = S_RESP;
            S_RESP: begin
                if (s_axi.s_axi_rready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, wait counter and response capture; rdata/rresp only
    // change in CAPT so they hold steady under back-pressure.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_addr  <= '0;
            r_cls   <= c_RESP_OKAY;
            r_cnt   <= 8'd0;
            r_rdata <= '0;
            r_rresp <= c_RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_addr <= s_axi.s_axi_araddr[63:3];
                r_cls  <= w_cls;
                r_cnt  <= c_CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (r_state == S_CAPT) begin
                r_rdata <= (r_cls == c_RESP_OKAY) ? mem_rdata : 64'd0;
                r_rresp <= r_cls;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_axi_rd_slave.sv
//============================================================================
// Module      : tb_ysyx_22050019_axi_rd_slave
// Description : Directed self-checking bench; three responders with LAT of
//               0, 3 and 10 share one clock and reset.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ysyx_22050019_axi_rd_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] araddr   [3];
    logic [2:0]  arvalid;
    logic [2:0]  rready;
    logic [2:0]  arready;
    logic [2:0]  rvalid;
    logic [2:0]  mem_ren;
    logic [63:0] rdata_o  [3];
    logic [1:0]  rresp_o  [3];
    logic [63:0] mem_raddr[3];
    logic [63:0] mem_rdata[3];

    int ren_cnt   [3] = '{0, 0, 0};
    int hs_cnt    [3] = '{0, 0, 0};
    logic [63:0] last_raddr [3];
    int viol   = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: one fixed word at 0x80000000, elsewhere
    // a pattern derived from the address.
    function automatic logic [63:0] memword(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h00100073_00000413;
        return {~a[31:0], a[31:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_22050019_axi_rd_slave_if u_if ();
        assign u_if.s_axi_araddr  = araddr[g];
        assign u_if.s_axi_arvalid = arvalid[g];
        assign u_if.s_axi_rready  = rready[g];
        assign arready[g]         = u_if.s_axi_arready;
        assign rvalid[g]          = u_if.s_axi_rvalid;
        assign rdata_o[g]         = u_if.s_axi_rdata;
        assign rresp_o[g]         = u_if.s_axi_rresp;

        ysyx_22050019_axi_rd_slave #(
            .LAT  ((g == 0) ? 0 : (g == 1) ? 3 : 10),
            .BASE (64'h8000_0000),
            .SIZE (64'h0800_0000)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst),
            .s_axi     (u_if.slave),
            .mem_ren   (mem_ren[g]),
            .mem_raddr (mem_raddr[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    // Synchronous-read memory model plus handshake / strobe monitors.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_ren[k]) begin
                mem_rdata[k]  <= memword(mem_raddr[k]);
                ren_cnt[k]    <= ren_cnt[k] + 1;
                last_raddr[k] <= mem_raddr[k];
            end
            if (arvalid[k] && arready[k]) hs_cnt[k] <= hs_cnt[k] + 1;
            if (arready[k] && rvalid[k])  viol <= viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read: handshake, measure latency, optionally hold rready low for
    // `stall` cycles, then complete the response.
    task automatic do_read(input int i, input logic [63:0] a, input int stall,
                           output int lat, output logic [63:0] d, output logic [1:0] r);
        int   n   = 0;
        logic bad = 1'b0;
        araddr[i] = a; arvalid[i] = 1'b1; rready[i] = 1'b0;
        while (!arready[i] && n < 400) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid[i] = 1'b0;
        chk("ar_drop", 64'(arready[i]), 64'd0);
        lat = 0;
        while (!rvalid[i] && lat < 400) begin @(posedge clk); #1; lat++; end
        chk("rvalid_seen", 64'(rvalid[i]), 64'd1);
        d = rdata_o[i]; r = rresp_o[i];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (!rvalid[i] || rdata_o[i] !== d || rresp_o[i] !== r || arready[i]) bad = 1'b1;
        end
        if (stall > 0) chk("stall_stable", 64'(bad), 64'd0);
        rready[i] = 1'b1;
        @(posedge clk); #1;
        rready[i] = 1'b0;
        chk("ar_back", 64'(arready[i]), 64'd1);
        chk("rvalid_clr", 64'(rvalid[i]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          r0;
        int          h0;
        int          n;
        logic        seen;
        logic [63:0] d;
        logic [1:0]  r;
        logic [63:0] a;

        for (int k = 0; k < 3; k++) araddr[k] = 64'd0;
        arvalid = 3'b000; rready = 3'b000;

        // Reset: arready held low while reset asserted, ignoring arvalid.
        arvalid = 3'b111;
        @(posedge clk); #1;
        chk("rst_arready", 64'(arready), 64'd0);
        @(posedge clk); #1;
        arvalid = 3'b000;
        rst = 1'b0;
        #1;
        chk("rel_arready", 64'(arready), 64'h7);
        chk("rel_rvalid",  64'(rvalid), 64'd0);
        chk("rel_memren",  64'(mem_ren), 64'd0);
        chk("rel_rdata0",  rdata_o[0], 64'd0);
        chk("rel_rresp0",  64'(rresp_o[0]), 64'd0);
        chk("rel_raddr0",  mem_raddr[0], 64'd0);

        // OKAY read at LAT=0.
        r0 = ren_cnt[0];
        do_read(0, 64'h8000_0000, 0, lat, d, r);
        chk("ok0_lat",   64'(lat), 64'd2);
        chk("ok0_data",  d, 64'h00100073_00000413);
        chk("ok0_resp",  64'(r), 64'd0);
        chk("ok0_ren",   64'(ren_cnt[0] - r0), 64'd1);
        chk("ok0_raddr", last_raddr[0], 64'h8000_0000);

        // LAT=3 with back-pressure, misaligned-to-dword but word-aligned address.
        r0 = ren_cnt[1];
        do_read(1, 64'h8000_0004, 5, lat, d, r);
        chk("ok3_lat",   64'(lat), 64'd5);
        chk("ok3_data",  d, 64'h00100073_00000413);
        chk("ok3_resp",  64'(r), 64'd0);
        chk("ok3_ren",   64'(ren_cnt[1] - r0), 64'd1);
        chk("ok3_raddr", last_raddr[1], 64'h8000_0000);

        // Error classes: never strobe memory, rdata forced to 0.
        r0 = ren_cnt[0];
        do_read(0, 64'h7FFF_FFF8, 0, lat, d, r);
        chk("dec_lo_lat",  64'(lat), 64'd2);
        chk("dec_lo_resp", 64'(r), 64'd3);
        chk("dec_lo_data", d, 64'd0);
        do_read(0, 64'h8800_0000, 0, lat, d, r);
        chk("dec_hi_resp", 64'(r), 64'd3);
        chk("dec_hi_data", d, 64'd0);
        do_read(0, 64'h8000_0002, 0, lat, d, r);
        chk("slv_lat",  64'(lat), 64'd2);
        chk("slv_resp", 64'(r), 64'd2);
        chk("slv_data", d, 64'd0);
        do_read(0, 64'h7000_0002, 0, lat, d, r);
        chk("dec_prio_resp", 64'(r), 64'd3);
        chk("err_no_ren", 64'(ren_cnt[0] - r0), 64'd0);
        r0 = ren_cnt[1];
        do_read(1, 64'h8800_0000, 0, lat, d, r);
        chk("dec3_lat",    64'(lat), 64'd5);
        chk("dec3_resp",   64'(r), 64'd3);
        chk("dec3_no_ren", 64'(ren_cnt[1] - r0), 64'd0);

        // Back-to-back fetches with arvalid held high and rready high.
        h0 = hs_cnt[0];
        a  = 64'h8000_0000;
        araddr[0] = a; arvalid[0] = 1'b1; rready[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!arready[0] && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            if (k == 7) arvalid[0] = 1'b0;
            else        araddr[0] = a + 64'd4;
            n = 0;
            while (!rvalid[0] && n < 50) begin @(posedge clk); #1; n++; end
            chk("b2b_data", rdata_o[0], memword({a[63:3], 3'b000}));
            chk("b2b_resp", 64'(rresp_o[0]), 64'd0);
            @(posedge clk); #1;
            a = a + 64'd4;
        end
        rready[0] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_hs",   64'(hs_cnt[0] - h0), 64'd8);
        chk("b2b_viol", 64'(viol), 64'd0);

        // LAT=10 full read, then a read aborted by reset while in WAIT.
        do_read(2, 64'h8000_0010, 0, lat, d, r);
        chk("ok10_lat",  64'(lat), 64'd12);
        chk("ok10_data", d, memword(64'h8000_0010));
        araddr[2] = 64'h8000_0100; arvalid[2] = 1'b1;
        n = 0;
        while (!arready[2] && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid[2] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        r0 = ren_cnt[2];
        rst = 1'b1;
        #1;
        chk("midrst_arready_idle", 64'(arready[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_arready", 64'(arready[2]), 64'd1);
        chk("midrst_rvalid",  64'(rvalid[2]), 64'd0);
        chk("midrst_rdata",   rdata_o[2], 64'd0);
        chk("midrst_rresp",   64'(rresp_o[2]), 64'd0);
        chk("midrst_memren",  64'(mem_ren[2]), 64'd0);
        chk("midrst_raddr",   mem_raddr[2], 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rvalid[2]) seen = 1'b1;
        end
        chk("midrst_no_resp", 64'(seen), 64'd0);
        chk("midrst_no_ren",  64'(ren_cnt[2] - r0), 64'd0);
        do_read(2, 64'h8000_0018, 0, lat, d, r);
        chk("post_lat",  64'(lat), 64'd12);
        chk("post_data", d, memword(64'h8000_0018));
        chk("post_resp", 64'(r), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22050019_axi_rd_slave.md
# ysyx_22050019_axi_rd_slave

AXI-style read responder that serves the instruction-fetch read master: accepts one read address, reads a 64-bit word from a synchronous-read memory port after a configurable wait, and returns it with a response code. It sits between the fetch unit's AR/R channels and the instruction SRAM model. It adds programmable latency so fetch stalls can be exercised. It also flags out-of-range and misaligned fetches.

## Interface
- `LAT`, 0: extra wait cycles inserted before the memory access (0..255).
- `BASE`, 64'h80000000: lowest valid byte address.
- `SIZE`, 64'h08000000: size of the valid window in bytes. An address is valid when BASE <= araddr < BASE+SIZE, compared unsigned in 64 bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset (asserted = 1).
- `s_axi_araddr`  in  64  read byte address.
- `s_axi_arvalid`  in  1  address valid.
- `s_axi_arready`  out  1  address accepted this cycle when high together with arvalid.
- `s_axi_rdata`  out  64  read data.
- `s_axi_rresp`  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- `s_axi_rvalid`  out  1  response valid.
- `s_axi_rready`  in  1  master accepts response.
- `mem_ren`  out  1  memory read strobe, high for exactly one cycle per OKAY access.
- `mem_raddr`  out  64  memory address, {araddr[63:3], 3'b000}.
- `mem_rdata`  in  64  memory data; valid the cycle after the cycle in which mem_ren is high.

## Operation
- **Single outstanding read.** No new address is accepted until the current response completes.
- **States:**
  - IDLE: `arready` = 1. On arvalid & arready, latch araddr and classify it, then go to WAIT if LAT > 0, otherwise to ISSUE.
  - WAIT: the 8-bit counter, loaded with LAT-1, decrements each cycle. When the counter reaches 0, go to ISSUE.
  - ISSUE: `mem_ren` = 1 only if the class is OKAY; `mem_raddr` is driven from the latched address. Go to CAPT.
  - CAPT: register `rdata` = mem_rdata for OKAY, or 0 for an error class. Register `rresp`. Go to RESP.
  - RESP: `rvalid` = 1. On rvalid & rready, go to IDLE.
- **Classification:**
  - DECERR (11): address outside the [BASE, BASE+SIZE) window. DECERR has priority over SLVERR.
  - SLVERR (10): araddr[1:0] != 0.
  - OKAY (00): otherwise.
  - Error classes never assert `mem_ren`.
- **Response stability.** `rdata` and `rresp` stay stable while rvalid is high and rready is low.
- **Reset (all outputs registered or decoded from state):**
  - State returns to IDLE.
  - `arready` = 0 while rst_n is high and 1 after release.
  - `rvalid` = 0, `rdata` = 0, `rresp` = 00, `mem_ren` = 0, `mem_raddr` = 0.
  - Reset mid-transaction aborts that transaction silently: no response is ever issued for it.
  - arvalid is ignored while rst_n is high.

## Timing
- AR handshake completes at edge E0.
- `mem_ren` is high during cycle E0+LAT .. E0+LAT+1.
- `rvalid` first rises after edge E0+LAT+2.
- Total latency from the AR handshake edge to the first cycle with rvalid high is LAT+2 edges. Error classes have identical timing.
- `arready` drops the cycle after the AR handshake. It returns to 1 the cycle after the R handshake.
- The earliest next AR handshake is the edge following the R handshake edge + 1 cycle.
- **Back-pressure.** rready held low keeps the block in RESP indefinitely, with `arready` = 0.
- **Counter wrap.** The counter never wraps; LAT = 255 gives a 257-cycle latency.
- **arvalid outside IDLE.** arvalid asserted outside IDLE has no effect; the master holds it.

## Test plan
- **OKAY read, LAT=0.** Memory word at 0x80000000 = 64'h00100073_00000413. arvalid with araddr=0x80000000 and rready=1.
  - mem_ren pulses one cycle with mem_raddr=0x80000000.
  - rvalid appears 2 edges after the handshake with rdata=64'h00100073_00000413 and rresp=00.
  - arready is back to 1 the next cycle.
- **Latency and back-pressure, LAT=3.** araddr=0x80000004, rready held 0 for 5 cycles after rvalid rises.
  - rvalid rises 5 edges after the handshake.
  - rdata and rresp are unchanged across the stall.
  - mem_raddr = 0x80000000.
  - arready stays 0 until one cycle after rready=1.
- **DECERR.** araddr=0x7FFFFFF8, then 0x88000000.
  - Each returns rresp=11 and rdata=0.
  - mem_ren is never asserted.
  - Latency equals the OKAY case.
- **SLVERR.** araddr=0x80000002 returns rresp=10 with mem_ren never asserted. araddr=0x70000002 returns rresp=11 (DECERR priority).
- **Back-to-back.** Eight sequential fetches 0x80000000, +4, ... with arvalid held high and rready=1.
  - Exactly one handshake occurs per response.
  - Responses arrive in order with correct data.
  - No AR is accepted while rvalid is high.
- **Reset mid-operation.** Assert rst_n for 1 cycle while in WAIT (LAT=10).
  - All outputs return to reset values.
  - No rvalid is produced for the aborted read.
  - A fresh read afterwards completes normally.
